// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter with valid/ready word intake and frame markers.
// Emits one bit per enabled clock; a word accepted on the last bit continues without a gap.
module piso_tx #(
  parameter int WIDTH      = 4,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             at_last;
  logic             accept;

  assign at_last = (cnt == LAST);
  // Ready is gated by rst so the source never sees a handshake while reset is held.
  assign din_ready = !rst && bit_en && ((state == IDLE) || at_last);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    if (accept) begin
      state_nxt = SHIFT;
      sreg_nxt  = din;
      cnt_nxt   = '0;
    end else if (bit_en && (state == SHIFT)) begin
      sreg_nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
      if (at_last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Output decode is purely from registered state.
  assign sout_valid  = (state == SHIFT);
  assign busy        = sout_valid;
  assign sout        = sout_valid ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : IDLE_LEVEL;
  assign frame_start = sout_valid && (cnt == '0);
  assign frame_end   = sout_valid && at_last;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a queue-of-pending-bits reference model checked every cycle,
// plus a chained 4-bit SIPO and an LSB-first instance.
module tb_piso_tx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         v   = 1'b0;
  logic [W-1:0] d   = '0;
  logic         rdy, sout, sv, fs, fe, busy;

  logic         en2 = 1'b0;
  logic         v2  = 1'b0;
  logic [W-1:0] d2  = '0;
  logic         rdy2, sout2, sv2, fs2, fe2, busy2;

  logic [W-1:0] sipo = '0;
  logic [5:0]   obs;

  int errors = 0;
  int checks = 0;
  bit mq[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .bit_en(en), .din(d), .din_valid(v), .din_ready(rdy),
    .sout(sout), .sout_valid(sv), .frame_start(fs), .frame_end(fe), .busy(busy));

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_en(en2), .din(d2), .din_valid(v2), .din_ready(rdy2),
    .sout(sout2), .sout_valid(sv2), .frame_start(fs2), .frame_end(fe2), .busy(busy2));

  assign obs = {sout, sv, fs, fe, busy, rdy};

  // Downstream SIPO clocked on the same enabled edges.
  always @(posedge clk) if (en) sipo <= {sipo[W-2:0], sout};

  // Expected outputs: the model is the list of bits still to be shown on sout.
  function automatic logic [5:0] exp_vec();
    int n = mq.size();
    logic s = (n > 0) ? mq[0] : 1'b0;
    return {s, n > 0, n == W, n == 1, n > 0, !rst && en && (n <= 1)};
  endfunction

  task automatic tick();
    bit ready_m;
    @(posedge clk);
    ready_m = en && (mq.size() <= 1);
    if (rst) mq.delete();
    else if (ready_m && v) begin
      mq.delete();
      for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
    end else if (en && mq.size() > 0) void'(mq.pop_front());
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 6'b0); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec() || obs !== 6'b000001) begin
        errors++; $display("FAIL idle_%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single();
    en = 1'b1; v = 1'b1; d = 4'b1011;
    tick();
    v = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL single_bit%0d obs=%b exp=%b", i, obs, exp_vec()); end
      tick();
    end
    checks++;
    if (sipo !== 4'b1011) begin errors++; $display("FAIL sipo_capture got=%b exp=%b", sipo, 4'b1011); end
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL single_idle obs=%b exp=%b", obs, 6'b000001); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got = '0;
    int taken = 0;
    bit acc;
    en = 1'b1; v = 1'b1; d = 4'hA;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_cyc%0d obs=%b exp=%b", c, obs, exp_vec()); end
      if (c > 0) got = {got[6:0], sout};
      acc = rdy && v;
      tick();
      if (acc) begin
        taken++;
        if (taken == 2) v = 1'b0; else d = 4'h3;
      end
    end
    checks++;
    if (got !== 8'b1010_0011) begin errors++; $display("FAIL b2b_stream got=%b exp=%b", got, 8'b1010_0011); end
  endtask

  task automatic test_stall();
    logic [7:0] pat = 8'b1011_0010;
    en = 1'b1; v = 1'b1; d = 4'b0110;
    tick();
    v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      en = pat[7-c];
      #1;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL stall_cyc%0d obs=%b exp=%b", c, obs, exp_vec()); end
      tick();
    end
    en = 1'b1; #1;
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL stall_end obs=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] words [2];
    en = 1'b0;
    words[0] = 4'b0001;
    words[1] = W'($urandom);
    for (int k = 0; k < 2; k++) begin
      en2 = 1'b1; v2 = 1'b1; d2 = words[k];
      #1;
      checks++;
      if (rdy2 !== 1'b1) begin errors++; $display("FAIL lsb_ready got=%b exp=1", rdy2); end
      tick();
      v2 = 1'b0;
      for (int i = 0; i < W; i++) begin
        checks++;
        if ({sout2, sv2, fs2, fe2} !== {words[k][i], 1'b1, i == 0, i == W - 1}) begin
          errors++;
          $display("FAIL lsb_w%0d_bit%0d got=%b exp=%b", k, i, {sout2, sv2, fs2, fe2},
                   {words[k][i], 1'b1, i == 0, i == W - 1});
        end
        tick();
      end
      checks++;
      if (sv2 !== 1'b0) begin errors++; $display("FAIL lsb_idle got=%b exp=0", sv2); end
    end
    en2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] got = '0;
    en = 1'b1; v = 1'b1; d = 4'hF;
    tick();
    v = 1'b0;
    tick(); tick();
    #2 rst = 1'b1; mq.delete();
    #1;
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL async_reset obs=%b exp=%b", obs, 6'b0); end
    tick();
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (obs !== exp_vec() || obs !== 6'b000001) begin
      errors++; $display("FAIL post_reset_idle obs=%b exp=%b", obs, 6'b000001);
    end
    v = 1'b1; d = 4'h5;
    tick();
    v = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_word_bit%0d obs=%b exp=%b", i, obs, exp_vec()); end
      got = {got[2:0], sout};
      tick();
    end
    checks++;
    if (got !== 4'b0101) begin errors++; $display("FAIL reset_word got=%b exp=%b", got, 4'b0101); end
  endtask

  task automatic test_random();
    bit acc;
    v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      en = ($urandom_range(0, 3) != 0);
      if (!v) begin
        v = $urandom_range(0, 1);
        d = W'($urandom);
      end
      #1;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_cyc%0d obs=%b exp=%b", c, obs, exp_vec()); end
      acc = exp_vec()[0] && v;
      tick();
      if (acc) v = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached=1 expected=0");
    $fatal(1);
  end
endmodule
